// File: rtl/lsu_pkg.sv
// Shared constants, state/fault encodings and lane helpers for the RV32I load/store unit.
// The optional WAIT_R timeout is enabled with the LSU_TIMEOUT_EN macro (see lsu_mem_ctrl).
package lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_REQ    = 3'd2,
        S_WAIT_R = 3'd3,
        S_RESP   = 3'd4
    } lsu_state_t;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_ILLEGAL  = 2'b10,
        FLT_TIMEOUT  = 2'b11
    } lsu_fault_t;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        if (is_store)
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

    // Signed and unsigned halfwords share f3[1:0]=01, so one test covers both.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] s;
        case (f3)
            F3_B:    s = 4'b0001 << off;
            F3_H:    s = 4'b0011 << off;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3)
            F3_B:    w = {4{d[7:0]}};
            F3_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extractor: selects the byte/halfword lane of the returned word
// and sign- or zero-extends it according to FUNCT3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_off, 3'b000} +: 8];
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'h0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'h0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store unit: single-outstanding valid/ready memory port, aligned writeback,
// fault reporting. Define LSU_TIMEOUT_EN to bound the wait for MEM_RVALID.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [6:0]  OPCODE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDR,
    input  logic [31:0] STORE_DATA,
    input  logic [4:0]  RD,
    output logic        MEM_VALID,
    input  logic        MEM_READY,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_WSTRB,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_RDATA,
    output logic        WB_VALID,
    output logic [4:0]  WB_RD,
    output logic [31:0] WB_DATA,
    output logic        FAULT,
    output logic [1:0]  FAULT_CAUSE
);

    lsu_state_t  r_state;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic [4:0]  r_rd;

    logic        w_is_load_op;
    logic        w_is_store_op;
    logic        w_f3_ok;
    logic        w_misal;
    logic [31:0] w_ld_data;

    assign w_is_load_op  = (OPCODE == OP_LOAD);
    assign w_is_store_op = (OPCODE == OP_STORE);
    assign w_f3_ok       = f3_legal(r_is_store, r_funct3);
    assign w_misal       = is_misaligned(r_funct3, r_addr[1:0]);

    lsu_load_align u_align (
        .i_rdata  (MEM_RDATA),
        .i_off    (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_ld_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'b0;
            r_addr      <= 32'b0;
            r_sdata     <= 32'b0;
            r_rd        <= 5'b0;
            REQ_READY   <= 1'b1;
            MEM_VALID   <= 1'b0;
            MEM_WE      <= 1'b0;
            MEM_ADDR    <= 32'b0;
            MEM_WSTRB   <= 4'b0;
            MEM_WDATA   <= 32'b0;
            WB_VALID    <= 1'b0;
            WB_RD       <= 5'b0;
            WB_DATA     <= 32'b0;
            FAULT       <= 1'b0;
            FAULT_CAUSE <= FLT_NONE;
`ifdef LSU_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            FAULT       <= 1'b0;
            FAULT_CAUSE <= FLT_NONE;
            WB_VALID    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        r_is_store <= w_is_store_op;
                        r_funct3   <= FUNCT3;
                        r_addr     <= ADDR;
                        r_sdata    <= STORE_DATA;
                        r_rd       <= RD;
                        // Anything other than load/store is swallowed while staying ready.
                        if (w_is_load_op || w_is_store_op) begin
                            r_state   <= S_CHECK;
                            REQ_READY <= 1'b0;
                        end
                    end
                end
                S_CHECK: begin
                    if (!w_f3_ok) begin
                        FAULT       <= 1'b1;
                        FAULT_CAUSE <= FLT_ILLEGAL;
                        REQ_READY   <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (w_misal) begin
                        FAULT       <= 1'b1;
                        FAULT_CAUSE <= FLT_MISALIGN;
                        REQ_READY   <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        MEM_VALID <= 1'b1;
                        MEM_WE    <= r_is_store;
                        MEM_ADDR  <= {r_addr[31:2], 2'b00};
                        MEM_WSTRB <= r_is_store ? store_strb(r_funct3, r_addr[1:0]) : 4'b0000;
                        MEM_WDATA <= r_is_store ? store_data(r_funct3, r_sdata) : 32'b0;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    // MEM_RVALID is deliberately not looked at until the request is accepted.
                    if (MEM_READY) begin
                        MEM_VALID <= 1'b0;
                        MEM_WE    <= 1'b0;
                        MEM_ADDR  <= 32'b0;
                        MEM_WSTRB <= 4'b0;
                        MEM_WDATA <= 32'b0;
                        if (r_is_store) begin
                            REQ_READY <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_state   <= S_WAIT_R;
                        end
`ifdef LSU_TIMEOUT_EN
                        r_cnt <= '0;
`endif
                    end
                end
                S_WAIT_R: begin
                    if (MEM_RVALID) begin
                        WB_VALID <= 1'b1;
                        WB_RD    <= r_rd;
                        WB_DATA  <= w_ld_data;
                        r_state  <= S_RESP;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        FAULT       <= 1'b1;
                        FAULT_CAUSE <= FLT_TIMEOUT;
                        REQ_READY   <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    WB_RD     <= 5'b0;
                    WB_DATA   <= 32'b0;
                    REQ_READY <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    REQ_READY <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed requests push expected memory, writeback
// and fault events; a monitor pops and compares whenever the DUT presents them.
module tb_lsu_mem_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [6:0]  OPCODE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDR;
    logic [31:0] STORE_DATA;
    logic [4:0]  RD;
    logic        MEM_VALID;
    logic        MEM_READY;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [3:0]  MEM_WSTRB;
    logic [31:0] MEM_WDATA;
    logic        MEM_RVALID;
    logic [31:0] MEM_RDATA;
    logic        WB_VALID;
    logic [4:0]  WB_RD;
    logic [31:0] WB_DATA;
    logic        FAULT;
    logic [1:0]  FAULT_CAUSE;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .OPCODE(OPCODE), .FUNCT3(FUNCT3), .ADDR(ADDR), .STORE_DATA(STORE_DATA), .RD(RD),
        .MEM_VALID(MEM_VALID), .MEM_READY(MEM_READY), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WSTRB(MEM_WSTRB), .MEM_WDATA(MEM_WDATA), .MEM_RVALID(MEM_RVALID),
        .MEM_RDATA(MEM_RDATA), .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
        .FAULT(FAULT), .FAULT_CAUSE(FAULT_CAUSE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic we; logic [3:0] strb; logic [31:0] wdata; int cyc; } mem_exp_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; int cyc; } wb_exp_t;
    typedef struct { logic [1:0] cause; int cyc; } flt_exp_t;

    mem_exp_t q_mem[$];
    wb_exp_t  q_wb[$];
    flt_exp_t q_flt[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: ready after ready_delay cycles of MEM_VALID, read data one cycle later.
    int          ready_delay = 0;
    int          wait_cnt = 0;
    bit          rv_enable = 1'b1;
    bit          rv_pend = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    initial begin
        MEM_READY = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = 32'h0;
        forever begin
            @(negedge CLK);
            MEM_RVALID = 1'b0;
            if (!rv_enable) rv_pend = 1'b0;
            if (rv_pend) begin
                MEM_RVALID = 1'b1;
                MEM_RDATA  = mem_rdata;
                rv_pend    = 1'b0;
            end
            MEM_READY = 1'b0;
            if (MEM_VALID && RST_N) begin
                if (wait_cnt >= ready_delay) begin
                    MEM_READY = 1'b1;
                    wait_cnt  = 0;
                    if (!MEM_WE) rv_pend = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor
    initial begin
        mem_exp_t m;
        wb_exp_t  w;
        flt_exp_t f;
        forever begin
            @(negedge CLK);
            #3;
            if (RST_N) begin
                if (MEM_VALID && MEM_READY) begin
                    if (q_mem.size() == 0) check("mem_unexpected", 32'(MEM_VALID), 32'h0);
                    else begin
                        m = q_mem.pop_front();
                        check("mem_addr", MEM_ADDR, m.addr);
                        check("mem_we", 32'(MEM_WE), 32'(m.we));
                        check("mem_wstrb", 32'(MEM_WSTRB), 32'(m.strb));
                        if (m.we) check("mem_wdata", MEM_WDATA, m.wdata);
                        if (m.cyc >= 0) check("mem_cycle", 32'(cyc), 32'(m.cyc));
                    end
                end
                if (WB_VALID) begin
                    if (q_wb.size() == 0) check("wb_unexpected", 32'(WB_VALID), 32'h0);
                    else begin
                        w = q_wb.pop_front();
                        check("wb_rd", 32'(WB_RD), 32'(w.rd));
                        check("wb_data", WB_DATA, w.data);
                        if (w.cyc >= 0) check("wb_cycle", 32'(cyc), 32'(w.cyc));
                    end
                end
                if (FAULT) begin
                    if (q_flt.size() == 0) check("fault_unexpected", 32'(FAULT), 32'h0);
                    else begin
                        f = q_flt.pop_front();
                        check("fault_cause", 32'(FAULT_CAUSE), 32'(f.cause));
                        if (f.cyc >= 0) check("fault_cycle", 32'(cyc), 32'(f.cyc));
                    end
                end
            end
        end
    end

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd, output int acc);
        int n = 0;
        @(negedge CLK);
        while (!REQ_READY && n < 50) begin @(negedge CLK); n++; end
        if (n >= 50) check("req_ready_timeout", 32'(REQ_READY), 32'h1);
        REQ_VALID = 1'b1; OPCODE = op; FUNCT3 = f3; ADDR = a; STORE_DATA = sd; RD = rd;
        acc = cyc;
        @(negedge CLK);
        REQ_VALID = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge CLK);
        while ((q_mem.size() != 0 || q_wb.size() != 0 || q_flt.size() != 0 || !REQ_READY) && n < 60) begin
            @(negedge CLK); n++;
        end
        if (n >= 60) check("drain_timeout", 32'(n), 32'h0);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata,
                           input logic [4:0] rd, input logic [31:0] exp_data, input bit lat);
        int acc;
        mem_rdata = rdata;
        issue(7'b0000011, f3, a, 32'h0, rd, acc);
        q_mem.push_back('{addr: {a[31:2], 2'b00}, we: 1'b0, strb: 4'b0000, wdata: 32'h0, cyc: lat ? acc + 2 : -1});
        q_wb.push_back('{rd: rd, data: exp_data, cyc: lat ? acc + 4 : -1});
        if (lat) begin
            while (cyc < acc + 4) @(negedge CLK);
            #4 check("ready_low_in_resp", 32'(REQ_READY), 32'h0);
            @(negedge CLK);
            #4 check("ready_after_resp", 32'(REQ_READY), 32'h1);
        end
        drain();
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                            input logic [3:0] strb, input logic [31:0] wdata);
        int acc;
        issue(7'b0100011, f3, a, sd, 5'd9, acc);
        q_mem.push_back('{addr: {a[31:2], 2'b00}, we: 1'b1, strb: strb, wdata: wdata, cyc: acc + 2});
        while (cyc < acc + 3) @(negedge CLK);
        #4 check("ready_after_store", 32'(REQ_READY), 32'h1);
        drain();
    endtask

    task automatic do_fault(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                            input logic [1:0] cause);
        int acc;
        issue(op, f3, a, 32'h12345678, 5'd4, acc);
        q_flt.push_back('{cause: cause, cyc: acc + 2});
        drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(REQ_READY), 32'h1);
        check({tag, "_outs_zero"},
              32'(|{MEM_VALID, MEM_WE, MEM_ADDR, MEM_WSTRB, MEM_WDATA, WB_VALID, WB_RD, WB_DATA, FAULT, FAULT_CAUSE}),
              32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n_wb;
        int n;
        logic [31:0] a0, d0;
        logic [3:0]  s0;
        RST_N = 1'b0; REQ_VALID = 1'b0; OPCODE = 7'h0; FUNCT3 = 3'h0;
        ADDR = 32'h0; STORE_DATA = 32'h0; RD = 5'h0;
        #12;
        check_reset_outputs("reset");
        @(negedge CLK);
        RST_N = 1'b1;

        // Loads
        do_load(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 1'b1);
        do_load(3'b000, 32'h0000_0203, 32'h8011_2233, 5'd7,  32'hFFFF_FF80, 1'b1);
        do_load(3'b100, 32'h0000_0203, 32'h8011_2233, 5'd8,  32'h0000_0080, 1'b0);
        do_load(3'b001, 32'h0000_0202, 32'h8011_2233, 5'd10, 32'hFFFF_8011, 1'b0);
        do_load(3'b101, 32'h0000_0202, 32'h8011_2233, 5'd11, 32'h0000_8011, 1'b0);
        do_load(3'b000, 32'h0000_0200, 32'h8011_2233, 5'd12, 32'h0000_0033, 1'b0);
        do_load(3'b001, 32'h0000_0200, 32'h8011_A233, 5'd13, 32'hFFFF_A233, 1'b0);
        do_load(3'b010, 32'h0000_0204, 32'h0102_0304, 5'd0,  32'h0102_0304, 1'b0);

        // Stores
        do_store(3'b000, 32'h0000_0301, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
        do_store(3'b001, 32'h0000_0302, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
        do_store(3'b010, 32'h0000_0400, 32'h1122_3344, 4'b1111, 32'h1122_3344);

        // Faults
        do_fault(7'b0100011, 3'b010, 32'h0000_0402, 2'b01);
        do_fault(7'b0000011, 3'b011, 32'h0000_0400, 2'b10);
        do_fault(7'b0000011, 3'b001, 32'h0000_0201, 2'b01);
        do_fault(7'b0100011, 3'b100, 32'h0000_0400, 2'b10);
        do_fault(7'b0000011, 3'b110, 32'h0000_0403, 2'b10);

        // Non-load/store opcode is consumed silently
        issue(7'b0110011, 3'b000, 32'h0000_0500, 32'h0, 5'd3, acc);
        #4 check("drop_ready", 32'(REQ_READY), 32'h1);
        check("drop_no_mem", 32'(MEM_VALID), 32'h0);
        drain();

        // Back-pressure in REQ, then reset while waiting for read data
        ready_delay = 5;
        mem_rdata = 32'hCAFE_F00D;
        issue(7'b0000011, 3'b010, 32'h0000_0600, 32'h0, 5'd6, acc);
        q_mem.push_back('{addr: 32'h0000_0600, we: 1'b0, strb: 4'b0000, wdata: 32'h0, cyc: -1});
        n = 0;
        while (!MEM_VALID && n < 10) begin @(negedge CLK); n++; end
        #4;
        a0 = MEM_ADDR; s0 = MEM_WSTRB; d0 = MEM_WDATA;
        check("bp_addr", a0, 32'h0000_0600);
        n = 0;
        while (!MEM_READY && n < 20) begin
            check("bp_valid", 32'(MEM_VALID), 32'h1);
            check("bp_addr_stable", MEM_ADDR, 32'h0000_0600);
            check("bp_strb_stable", 32'(MEM_WSTRB), 32'(s0));
            check("bp_wdata_stable", MEM_WDATA, d0);
            check("bp_ready_low", 32'(REQ_READY), 32'h0);
            @(negedge CLK); #4; n++;
        end
        check("bp_wait_cycles", 32'(n), 32'd5);
        ready_delay = 0;
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1 check_reset_outputs("midreset");
        @(posedge CLK);
        #2 RST_N = 1'b1;
        n_wb = 0;
        repeat (4) begin
            @(negedge CLK);
            #4 if (WB_VALID) n_wb++;
        end
        check("no_wb_after_reset", 32'(n_wb), 32'h0);
        check("ready_after_reset", 32'(REQ_READY), 32'h1);

`ifdef LSU_TIMEOUT_EN
        rv_enable = 1'b0;
        issue(7'b0000011, 3'b010, 32'h0000_0700, 32'h0, 5'd3, acc);
        q_mem.push_back('{addr: 32'h0000_0700, we: 1'b0, strb: 4'b0000, wdata: 32'h0, cyc: acc + 2});
        q_flt.push_back('{cause: 2'b11, cyc: acc + 7});
        while (cyc < acc + 7) @(negedge CLK);
        #4 check("timeout_ready", 32'(REQ_READY), 32'h1);
        drain();
        rv_enable = 1'b1;
`endif

        check("final_mem_q", 32'(q_mem.size()), 32'h0);
        check("final_wb_q", 32'(q_wb.size()), 32'h0);
        check("final_flt_q", 32'(q_flt.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
RV32I load/store unit for the execute/memory boundary.
- Consumes the effective address computed by the ALU (RS1_DATA + sign-extended IMM12) plus RS2_DATA for stores.
- Drives a single-outstanding valid/ready data-memory port.
- Aligns and extends load data, returns it on a one-cycle writeback strobe.
- Reports misaligned or illegal accesses without touching memory.

Parameters:
TIMEOUT_CYCLES, 255, cycles waited for MEM_RVALID before fault (LSU_TIMEOUT_EN only); counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
REQ_VALID  input  1  execute stage presents a request
REQ_READY  output  1  unit can accept; high only in IDLE
OPCODE  input  7  0000011 load, 0100011 store; other values dropped
FUNCT3  input  3  access size/sign
ADDR  input  32  effective byte address (ALU result)
STORE_DATA  input  32  RS2_DATA
RD  input  5  load destination register
MEM_VALID  output  1  memory request valid
MEM_READY  input  1  memory accepts request
MEM_WE  output  1  1 store, 0 load
MEM_ADDR  output  32  {ADDR[31:2],2'b00}
MEM_WSTRB  output  4  byte enables (0000 for loads)
MEM_WDATA  output  32  lane-shifted store data
MEM_RVALID  input  1  load data valid
MEM_RDATA  input  32  load word
WB_VALID  output  1  one-cycle writeback strobe
WB_RD  output  5  destination register
WB_DATA  output  32  extended load result
FAULT  output  1  one-cycle fault pulse
FAULT_CAUSE  output  2  01 misaligned, 10 illegal funct3, 11 timeout; 00 when FAULT low

Behaviour:
- Reset (asynchronous, any state): state IDLE.
  - All outputs 0 except REQ_READY=1.
  - Captured request registers cleared.
  - A MEM_RVALID arriving after reset is ignored in IDLE.
- Accept: REQ_VALID & REQ_READY in IDLE. Latch OPCODE, FUNCT3, ADDR, STORE_DATA, RD.
- Non-load/store opcode: consumed and dropped; stays IDLE, no fault.
- Legal FUNCT3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Else FAULT with cause 10.
- Misaligned: halfword with ADDR[0]=1, or word with ADDR[1:0]!=00 -> FAULT with cause 01. Illegal FUNCT3 takes priority over misalignment.
- FSM states: IDLE, CHECK, REQ, WAIT_R, RESP.
  - IDLE -> CHECK on accept.
  - CHECK -> IDLE with FAULT pulse if illegal or misaligned.
  - CHECK -> REQ otherwise.
  - REQ: MEM_VALID=1, address/strobe/data held stable until MEM_READY.
    - Store and MEM_READY -> IDLE; no writeback.
    - Load and MEM_READY -> WAIT_R.
  - WAIT_R: on MEM_RVALID, register aligned data -> RESP.
  - RESP: WB_VALID=1 for exactly one cycle with WB_RD/WB_DATA -> IDLE.
- Latency with a zero-wait memory (MEM_READY and MEM_RVALID high in the cycle after they are first sampled):
  - Accept at cycle 0.
  - MEM_VALID at cycle 2.
  - WB_VALID at cycle 4.
  - REQ_READY next high the cycle after RESP (loads) or after REQ completes (stores).
- MEM_RVALID in the same cycle MEM_READY is sampled in REQ is not legal memory behaviour; the unit ignores it.
- Load extraction:
  - Byte lane = ADDR[1:0]; halfword = ADDR[1] selects the upper/lower half.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Store lanes:
  - SB: WSTRB = 0001 << ADDR[1:0]; WDATA = byte replicated into all four lanes.
  - SH: WSTRB = 0011 << ADDR[1:0]; WDATA = halfword replicated into both halves.
  - SW: WSTRB = 1111.
- WB_RD = 0 is still reported; the register file discards it.

Optional Feature:
Macro LSU_TIMEOUT_EN.
- Defined: counter clears on entry to WAIT_R and increments each cycle while MEM_RVALID is low. On reaching TIMEOUT_CYCLES: FAULT with cause 11, return to IDLE, no writeback; late MEM_RVALID is ignored.
- Undefined: no counter; WAIT_R waits indefinitely; cause 11 is never produced.

Decomposition:
Package lsu_pkg holds:
- opcode constants OP_LOAD and OP_STORE
- FUNCT3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
- state enum lsu_state_t
- fault cause enum lsu_fault_t

Sub-module lsu_load_align: combinational (MEM_RDATA, ADDR[1:0], FUNCT3) -> 32-bit extended result, unit-tested standalone.

Test Plan:
- LW at ADDR 0x100, MEM_RDATA 0xDEADBEEF, zero-wait memory -> MEM_ADDR 0x100, WSTRB 0000, WB_VALID at cycle 4 with WB_DATA 0xDEADBEEF and WB_RD echoed.
- LB and LBU at ADDR 0x203, MEM_RDATA 0x80112233 -> WB_DATA 0xFFFFFF80 and 0x00000080; LH at 0x202 -> 0xFFFF8011.
- SB at ADDR 0x301 with STORE_DATA 0x000000AB -> MEM_WE 1, WSTRB 0010, WDATA 0xABABABAB, MEM_ADDR 0x300, no WB_VALID.
- SW at ADDR 0x402 -> FAULT 1 cycle, cause 01, MEM_VALID never asserted. Load with FUNCT3 011 -> cause 10.
- MEM_READY held low 5 cycles in REQ -> MEM_VALID, MEM_ADDR, WSTRB and WDATA stable throughout; REQ_READY low. Then RST_N low mid-WAIT_R -> all outputs reset immediately, and a following MEM_RVALID produces no WB_VALID.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, MEM_RVALID never asserted -> FAULT cause 11 exactly 4 cycles after entering WAIT_R, then REQ_READY=1.
